logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
//
// PURPOSE
//   Parametrised, pipelined bitwise logic unit. Successor to the fixed
//   32-bit combinational AND: adds a configurable width, an op select for six
//   bitwise functions, and an accumulating AND mode. It also adds valid/ready
//   handshaking with back-pressure, result flags, and a configurable pipeline
//   depth. Sits in the ALU datapath beside the adder/shifter as the logic-op
//   execution lane.
//
// PARAMETERS
//   WIDTH        32  operand/result width in bits (>= 1)
//   PIPE_STAGES   2  register stages from operand acceptance to result (1..4)
//
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operands and op present this cycle
//   in_ready   out  1      unit can accept operands this cycle
//   op         in   3      function select (see BEHAVIOUR)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      f/zero/ones hold a valid result
//   out_ready  in   1      consumer takes result this cycle
//   f          out  WIDTH  result
//   zero       out  1      f == 0
//   ones       out  1      f == all ones
//
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge):
//     - all stage valids, out_valid, f, zero and ones are 0.
//     - accumulator acc is all ones.
//     - Reset overrides any in-flight transfer; in-flight results are discarded.
//   - Op encoding:
//     - 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR.
//     - 110 ACC_AND: f = acc & a & b; acc <= f.
//     - 111 ACC_CLR: f = all ones; acc <= all ones (a, b ignored).
//   - Accept: a transfer happens when in_valid && in_ready.
//     - op/a/b are ignored when no transfer occurs.
//     - acc updates only on an accepted ACC_AND/ACC_CLR, in the same cycle as
//       acceptance. Back-to-back ACC ops therefore chain with no bubble.
//   - Result is computed at acceptance and carried through PIPE_STAGES
//     registers; flags are registered alongside f.
//   - Latency: a result accepted at edge N is on f/out_valid after edge
//     N+PIPE_STAGES-1, i.e. visible in cycle N+PIPE_STAGES.
//   - Stall: stall = out_valid && !out_ready.
//     - in_ready = !stall (combinational).
//     - While stalled, every stage holds its contents and f/flags are stable.
//   - Bubbles: an empty stage (valid=0) does not stall upstream stages; the
//     pipeline advances whenever the last stage is empty or is being drained.
//   - Throughput is 1 result/cycle with out_ready held high.
//   - Results emerge in acceptance order; none is dropped or duplicated.
//   - out_valid must not drop while out_ready=0.
//   - A simultaneous drain and accept in the same cycle is legal and loses
//     nothing.
//   - No arithmetic: all ops are pure bitwise over WIDTH bits, with no carry
//     and no sign handling.
//
// TESTING  (WIDTH=32, PIPE_STAGES=2 unless noted)
//   1. AND, a=b=32'h8000_0001, out_ready=1
//      -> f=32'h8000_0001 two cycles after accept; zero=0, ones=0.
//   2. Ops 000..101 back-to-back on a=32'h0000_FFF5, b=32'h0000_3D03
//      -> AND 3D01, OR FFF7, XOR C2F6, NOR FFFF_0008, NAND FFFF_C2FE,
//         XNOR FFFF_3D09 on consecutive cycles; in_ready stays 1.
//   3. ACC_CLR, then ACC_AND with (F0F0_FFFF, FFFF_FFFF), then (FF00_FF00, FFFF_FFFF)
//      -> f = FFFF_FFFF, F0F0_FFFF, F000_FF00; a later ACC_CLR gives ones=1.
//   4. AND with a=0: zero=1. Stream 4 ops, hold out_ready=0 for 3 cycles
//      -> in_ready=0 while out_valid=1; f stable; all 4 results arrive in order.
//   5. rst_n=0 while 2 results in flight
//      -> next cycle out_valid=0 and f=0; a following ACC_AND with a=b=all ones
//         gives f=all ones (acc reset).
//   6. PIPE_STAGES=1 and 4 rebuild of test 2 -> same values, latency 1 and 4.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic lane: six logic ops plus an accumulating AND, with
// valid/ready flow control and registered zero/all-ones flags.
module logic_unit_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             ones
);

  typedef enum logic [2:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_XOR     = 3'b010,
    OP_NOR     = 3'b011,
    OP_NAND    = 3'b100,
    OP_XNOR    = 3'b101,
    OP_ACC_AND = 3'b110,
    OP_ACC_CLR = 3'b111
  } op_t;

  op_t              op_sel;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_ones;
  logic             stall;
  logic             advance;
  logic             accept;
  logic             acc_op;

  logic             stg_v [PIPE_STAGES];
  logic [WIDTH-1:0] stg_f [PIPE_STAGES];
  logic             stg_z [PIPE_STAGES];
  logic             stg_o [PIPE_STAGES];

  assign op_sel   = op_t'(op);
  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign acc_op   = (op_sel == OP_ACC_AND) || (op_sel == OP_ACC_CLR);

  always_comb begin
    res = '0;
    case (op_sel)
      OP_AND:     res = a & b;
      OP_OR:      res = a | b;
      OP_XOR:     res = a ^ b;
      OP_NOR:     res = ~(a | b);
      OP_NAND:    res = ~(a & b);
      OP_XNOR:    res = ~(a ^ b);
      OP_ACC_AND: res = acc & a & b;
      OP_ACC_CLR: res = '1;
      default:    res = '0;
    endcase
  end

  assign res_zero = (res == '0);
  assign res_ones = &res;

  // The whole pipe moves as one whenever the output is empty or being drained;
  // bubbles simply shift along, so an empty stage never holds anything back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '1;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        stg_v[i] <= 1'b0;
        stg_f[i] <= '0;
        stg_z[i] <= 1'b0;
        stg_o[i] <= 1'b0;
      end
    end else begin
      if (accept && acc_op)
        acc <= res;
      if (advance) begin
        for (int i = PIPE_STAGES - 1; i > 0; i--) begin
          stg_v[i] <= stg_v[i-1];
          stg_f[i] <= stg_f[i-1];
          stg_z[i] <= stg_z[i-1];
          stg_o[i] <= stg_o[i-1];
        end
        stg_v[0] <= accept;
        if (accept) begin
          stg_f[0] <= res;
          stg_z[0] <= res_zero;
          stg_o[0] <= res_ones;
        end
      end
    end
  end

  assign out_valid = stg_v[PIPE_STAGES-1];
  assign f         = stg_f[PIPE_STAGES-1];
  assign zero      = stg_z[PIPE_STAGES-1];
  assign ones      = stg_o[PIPE_STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a 2-stage unit under full flow control
// plus 1- and 4-stage copies fed the same accepted stream.
module tb_logic_unit_pipe;

  typedef struct {
    logic [31:0] f;
    logic        zero;
    logic        ones;
    int          cyc;
    bit          lat;
  } sb_t;

  localparam int LAT [3] = '{2, 1, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;
  logic        side_valid;
  logic        side_rdy [3];
  logic        ov [3];
  logic [31:0] fo [3];
  logic        zo [3];
  logic        oo [3];

  int          vectors = 0;
  int          misses = 0;
  int          cyc = 0;
  logic [31:0] drv_exp;
  logic [31:0] m_acc;
  bit          lat_en;
  bit          done;
  bit          prev_stall;
  logic [31:0] prev_f;
  sb_t         sbq [3][$];
  sb_t         mon_e;

  assign side_valid  = in_valid && in_ready;
  assign side_rdy[0] = in_ready;

  logic_unit_pipe #(.WIDTH(32), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready),
    .f(fo[0]), .zero(zo[0]), .ones(oo[0])
  );

  logic_unit_pipe #(.WIDTH(32), .PIPE_STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(side_valid), .in_ready(side_rdy[1]),
    .op(op), .a(a), .b(b), .out_valid(ov[1]), .out_ready(1'b1),
    .f(fo[1]), .zero(zo[1]), .ones(oo[1])
  );

  logic_unit_pipe #(.WIDTH(32), .PIPE_STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(side_valid), .in_ready(side_rdy[2]),
    .op(op), .a(a), .b(b), .out_valid(ov[2]), .out_ready(1'b1),
    .f(fo[2]), .zero(zo[2]), .ones(oo[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] acc);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x | y);
      3'd4:    return ~(x & y);
      3'd5:    return ~(x ^ y);
      3'd6:    return acc & x & y;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Offer one operation and hold it until the main unit takes it.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] exp);
    bit taken;
    taken    = 1'b0;
    op       = o;
    a        = x;
    b        = y;
    drv_exp  = exp;
    in_valid = 1'b1;
    for (int k = 0; k < 64 && !taken; k++) begin
      @(negedge clk);
      if (in_ready) taken = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!taken) begin
      checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (o == 3'd6) m_acc = m_acc & x & y;
      if (o == 3'd7) m_acc = 32'hFFFF_FFFF;
    end
  endtask

  task automatic applyModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    applyStimulus(o, x, y, model(o, x, y, m_acc));
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Results are pushed for every lane when the main unit accepts, and popped
  // whenever a lane hands a result to its consumer.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < 3; l++) sbq[l].delete();
      prev_stall = 1'b0;
    end else begin
      for (int l = 0; l < 3; l++) begin
        if (ov[l] && (l != 0 || out_ready)) begin
          if (sbq[l].size() == 0) begin
            checkOutput($sformatf("L%0d_unexpected", l), {31'd0, ov[l]}, 32'd0);
          end else begin
            mon_e = sbq[l].pop_front();
            checkOutput($sformatf("L%0d_f", l), fo[l], mon_e.f);
            checkOutput($sformatf("L%0d_zero", l), {31'd0, zo[l]}, {31'd0, mon_e.zero});
            checkOutput($sformatf("L%0d_ones", l), {31'd0, oo[l]}, {31'd0, mon_e.ones});
            if (mon_e.lat)
              checkOutput($sformatf("L%0d_latency", l), cyc - mon_e.cyc, LAT[l]);
          end
        end
      end
      if (prev_stall) begin
        checkOutput("hold_valid", {31'd0, ov[0]}, 32'd1);
        checkOutput("hold_f", fo[0], prev_f);
      end
      prev_stall = ov[0] && !out_ready;
      prev_f     = fo[0];
      if (in_valid && in_ready) begin
        for (int l = 0; l < 3; l++) begin
          mon_e.f    = drv_exp;
          mon_e.zero = (drv_exp == 32'd0);
          mon_e.ones = &drv_exp;
          mon_e.cyc  = cyc;
          mon_e.lat  = (l == 0) ? lat_en : 1'b1;
          sbq[l].push_back(mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; a = '0; b = '0; drv_exp = '0;
    m_acc = 32'hFFFF_FFFF; lat_en = 1'b1; done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      checkOutput($sformatf("rst_L%0d_valid", l), {31'd0, ov[l]}, 32'd0);
      checkOutput($sformatf("rst_L%0d_f", l), fo[l], 32'd0);
      checkOutput($sformatf("rst_L%0d_flags", l), {30'd0, zo[l], oo[l]}, 32'd0);
    end
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] single AND");
    applyStimulus(3'd0, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001);
    idleCycles(6);

    $display("[TB] six ops back-to-back");
    c0 = cyc;
    applyStimulus(3'd0, 32'h0000_FFF5, 32'h0000_3D03, 32'h0000_3D01);
    applyStimulus(3'd1, 32'h0000_FFF5, 32'h0000_3D03, 32'h0000_FFF7);
    applyStimulus(3'd2, 32'h0000_FFF5, 32'h0000_3D03, 32'h0000_C2F6);
    applyStimulus(3'd3, 32'h0000_FFF5, 32'h0000_3D03, 32'hFFFF_0008);
    applyStimulus(3'd4, 32'h0000_FFF5, 32'h0000_3D03, 32'hFFFF_C2FE);
    applyStimulus(3'd5, 32'h0000_FFF5, 32'h0000_3D03, 32'hFFFF_3D09);
    checkOutput("six_op_cycles", cyc - c0, 32'd6);
    idleCycles(6);

    $display("[TB] accumulator chain");
    applyStimulus(3'd7, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(3'd6, 32'hF0F0_FFFF, 32'hFFFF_FFFF, 32'hF0F0_FFFF);
    applyStimulus(3'd6, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'hF000_FF00);
    applyStimulus(3'd0, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'h0F0F_0000);
    applyStimulus(3'd7, 32'h0, 32'h0, 32'hFFFF_FFFF);
    idleCycles(6);

    $display("[TB] back-pressure");
    lat_en = 1'b0;
    fork
      begin
        applyStimulus(3'd0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        for (int k = 0; k < 3; k++)
          applyModel(3'($urandom_range(0, 5)), $urandom, $urandom);
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 20 && !ov[0]; k++) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idleCycles(8);
    lat_en = 1'b1;

    $display("[TB] reset with results in flight");
    applyModel(3'd6, 32'h0000_FFFF, 32'hFFFF_FFFF);
    applyModel(3'd1, 32'h0000_0001, 32'h0000_0002);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      checkOutput($sformatf("flush_L%0d_valid", l), {31'd0, ov[l]}, 32'd0);
      checkOutput($sformatf("flush_L%0d_f", l), fo[l], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_acc = 32'hFFFF_FFFF;
    applyStimulus(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idleCycles(8);

    $display("[TB] random stream with random back-pressure");
    lat_en = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++)
          applyModel(3'($urandom_range(0, 7)), $urandom, $urandom | 32'hF0F0_0000);
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idleCycles(10);
    for (int l = 0; l < 3; l++)
      checkOutput($sformatf("L%0d_drained", l), sbq[l].size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
